vid_stream_out: RTL and testbench

Parametrised successor to the fixed-format clocked-video output used between the frame buffer and the VGA pins. It accepts an Avalon-ST video stream and buffers payload pixels in an internal FIFO. It generates programmable VGA timing with configurable symbols-per-pixel, sync polarity and FIFO depth. It locks the stream to the frame raster, reports underflow, and resynchronises itself without a system reset.

---
 rtl/vid_stream_out_pkg.sv | 30 +++
 rtl/vid_sfifo.sv | 56 +++++
 rtl/vid_stream_out.sv | 161 ++++++++++++++++
 tb/tb_vid_stream_out.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_stream_out_pkg.sv
// Shared types and constant helpers for the clocked-video output block.
package vid_stream_out_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT  = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } state_t;

  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Minimum 1 so that degenerate sizes still yield a legal vector width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vid_sfifo.sv
// Show-ahead synchronous FIFO with flush; flush overrides a same-cycle push.
module vid_sfifo
  import vid_stream_out_pkg::*;
#(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  // A pop frees the slot in the same cycle, so a full FIFO may accept a push alongside it.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/vid_stream_out.sv
// Avalon-ST video to VGA raster output with frame lock and underflow recovery.
//   state      | meaning
//   SYNC_WAIT  | FIFO flushed, input discarded until a video header arrives
//   WAIT_FRAME | buffering payload, waiting for frame end with a first-tagged head
//   RUN        | one pop per active pixel, first tag checked against pixel (0,0)
module vid_stream_out
  import vid_stream_out_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int BPS        = 8,
  parameter int CHANNELS   = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_POL   = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BPS*CHANNELS-1:0]   din_data,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      din_sop,
  input  logic                      din_eop,
  output logic [BPS*CHANNELS-1:0]   vid_data,
  output logic                      vid_datavalid,
  output logic                      vid_h_sync,
  output logic                      vid_v_sync,
  output logic                      vid_h,
  output logic                      vid_v,
  output logic                      vid_f,
  output logic                      underflow,
  output logic                      locked
);

  localparam int DW  = BPS * CHANNELS;
  localparam int H_T = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_T = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW  = clog2(H_T);
  localparam int VW  = clog2(V_T);
  localparam int LW  = clog2(FIFO_DEPTH) + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_T - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_T - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ON = (SYNC_POL != 0);

  state_t          state;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            pkt_video;
  logic            first_pend;

  logic [DW:0]     fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [LW-1:0]   fifo_level;
  logic [LW-1:0]   lvl_nxt;

  logic active, first_pix, frame_end, xfer, hdr_video;
  logic run_err, flush, push, pop, to_run, into_sync;

  assign vid_f     = 1'b0;
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign first_pix = (h_cnt == '0) && (v_cnt == '0);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign xfer      = din_valid && din_ready;
  assign hdr_video = xfer && din_sop && (din_data[3:0] == PKT_TYPE_VIDEO);

  // A frame must start on a first-tagged word, and only there.
  assign run_err   = (state == RUN) && active && (fifo_empty || (fifo_head[DW] != first_pix));
  assign flush     = (state == SYNC_WAIT) || run_err;
  assign push      = xfer && !din_sop && pkt_video && (state != SYNC_WAIT) && (!fifo_full || pop);
  assign pop       = (state == RUN) && active && !run_err;
  assign to_run    = (state == WAIT_FRAME) && frame_end && !fifo_empty && fifo_head[DW];
  assign into_sync = ((state == SYNC_WAIT) && !hdr_video) || run_err;
  assign lvl_nxt   = flush ? '0 : (fifo_level + LW'(push) - LW'(pop));

  vid_sfifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   ({first_pend, din_data}),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SYNC_WAIT;
      pkt_video     <= 1'b0;
      first_pend    <= 1'b0;
      din_ready     <= 1'b0;
      vid_data      <= '0;
      vid_datavalid <= 1'b0;
      vid_h_sync    <= ~SYNC_ON;
      vid_v_sync    <= ~SYNC_ON;
      vid_h         <= 1'b0;
      vid_v         <= 1'b0;
      underflow     <= 1'b0;
      locked        <= 1'b0;
    end else begin
      case (state)
        SYNC_WAIT:  if (hdr_video) state <= WAIT_FRAME;
        WAIT_FRAME: if (to_run)    state <= RUN;
        RUN:        if (run_err)   state <= SYNC_WAIT;
        default:                   state <= SYNC_WAIT;
      endcase

      if (xfer) begin
        if (din_sop) begin
          pkt_video  <= (din_data[3:0] == PKT_TYPE_VIDEO) && !din_eop;
          first_pend <= 1'b1;
        end else begin
          if (push)    first_pend <= 1'b0;
          if (din_eop) pkt_video  <= 1'b0;
        end
      end

      // Ready is registered, so it is computed from next-cycle state and level.
      din_ready     <= into_sync || (lvl_nxt != LW'(FIFO_DEPTH));
      vid_data      <= pop ? fifo_head[DW-1:0] : '0;
      vid_datavalid <= active;
      vid_h         <= !(h_cnt < H_ACT);
      vid_v         <= !(v_cnt < V_ACT);
      vid_h_sync    <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_ON : ~SYNC_ON;
      vid_v_sync    <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_ON : ~SYNC_ON;
      underflow     <= run_err;
      locked        <= ((state == WAIT_FRAME) && to_run) || ((state == RUN) && !run_err);
    end
  end

endmodule

// File: tb/tb_vid_stream_out.sv
// Randomized bench for vid_stream_out on a 7x5 raster against a queue-based frame model.
module tb_vid_stream_out;

  localparam int DW = 24;
  localparam int HT = 7;
  localparam int VT = 5;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [DW-1:0] din_data = '0;
  logic          din_valid = 1'b0;
  logic          din_sop = 1'b0;
  logic          din_eop = 1'b0;
  logic          din_ready;
  logic [DW-1:0] vid_data;
  logic          vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v, vid_f;
  logic          underflow, locked;

  always #5 clk = ~clk;

  vid_stream_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BPS(8), .CHANNELS(3), .FIFO_DEPTH(8), .SYNC_POL(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
    .din_sop(din_sop), .din_eop(din_eop),
    .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .vid_h(vid_h), .vid_v(vid_v), .vid_f(vid_f),
    .underflow(underflow), .locked(locked)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: raster position from a cycle count, FIFO as a queue of {first, pixel}.
  int            m_mode;   // 0 discarding, 1 waiting for frame start, 2 streaming
  logic [DW:0]   q[$];
  bit            m_pvid, m_fpend, m_ready;
  int            t;
  logic [DW-1:0] e_data;
  bit            e_dv, e_hs, e_vs, e_h, e_v, e_uf, e_lock, e_rdy;
  bit            last_xfer;
  int            gap_max = 0;

  task automatic model_reset();
    m_mode = 0; q.delete(); m_pvid = 0; m_fpend = 0; m_ready = 0; t = 0;
  endtask

  task automatic model_step();
    int h, v;
    bit act, fe, xfer, err, push, to_run, to_wait;
    logic [DW:0] w;
    h = t % HT;
    v = (t / HT) % VT;
    act  = (h < 4) && (v < 2);
    fe   = (h == HT - 1) && (v == VT - 1);
    xfer = din_valid && m_ready;
    err = 0;
    e_data = '0;
    if (m_mode == 2 && act) begin
      if (q.size() == 0 || q[0][DW] != ((h == 0) && (v == 0))) err = 1;
      else begin
        w = q.pop_front();
        e_data = w[DW-1:0];
      end
    end
    to_run  = (m_mode == 1) && fe && (q.size() > 0) && q[0][DW];
    to_wait = (m_mode == 0) && xfer && din_sop && (din_data[3:0] == 4'h0);
    push    = xfer && !din_sop && m_pvid && (m_mode != 0);
    if (m_mode == 0 || err) q.delete();
    else if (push) q.push_back({m_fpend, din_data});
    if (xfer) begin
      if (din_sop) begin
        m_pvid  = (din_data[3:0] == 4'h0) && !din_eop;
        m_fpend = 1;
      end else begin
        if (push) m_fpend = 0;
        if (din_eop) m_pvid = 0;
      end
    end
    if (to_wait) m_mode = 1;
    if (to_run)  m_mode = 2;
    if (err)     m_mode = 0;
    e_dv   = act;
    e_h    = (h >= 4);
    e_v    = (v >= 2);
    e_hs   = !(h == 5);
    e_vs   = !(v == 3);
    e_uf   = err;
    e_lock = (m_mode == 2);
    m_ready = (m_mode == 0) || (q.size() != 8);
    e_rdy  = m_ready;
    last_xfer = xfer;
    t++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("vid_data", 32'(vid_data), 32'(e_data));
    chk("vid_datavalid", 32'(vid_datavalid), 32'(e_dv));
    chk("vid_h_sync", 32'(vid_h_sync), 32'(e_hs));
    chk("vid_v_sync", 32'(vid_v_sync), 32'(e_vs));
    chk("vid_h", 32'(vid_h), 32'(e_h));
    chk("vid_v", 32'(vid_v), 32'(e_v));
    chk("vid_f", 32'(vid_f), 32'd0);
    chk("underflow", 32'(underflow), 32'(e_uf));
    chk("locked", 32'(locked), 32'(e_lock));
    chk("din_ready", 32'(din_ready), 32'(e_rdy));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit sop, input bit eop);
    int n;
    din_data = d; din_sop = sop; din_eop = eop; din_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_xfer && n < 200);
    if (!last_xfer) chk("beat_timeout", 32'd0, 32'd1);
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    din_data = DW'($urandom);
    repeat ($urandom_range(0, gap_max)) step();
  endtask

  // base < 0 selects random payload; otherwise payload is base, base+1, ...
  task automatic send_pkt(input logic [3:0] ptype, input int n, input int base);
    logic [DW-1:0] d;
    d = (DW'($urandom) & 24'hFFFFF0) | DW'(ptype);
    send_beat(d, 1'b1, n == 0);
    for (int i = 0; i < n; i++) begin
      d = (base < 0) ? DW'($urandom) : DW'(base + i);
      send_beat(d, 1'b0, i == n - 1);
    end
  endtask

  task automatic wait_lock(input string tag);
    int n;
    n = 0;
    while (!locked && n < 150) begin
      step();
      n++;
    end
    chk(tag, 32'(locked), 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_vid_data", 32'(vid_data), 32'd0);
    chk("rst_datavalid", 32'(vid_datavalid), 32'd0);
    chk("rst_h_sync", 32'(vid_h_sync), 32'd1);
    chk("rst_v_sync", 32'(vid_v_sync), 32'd1);
    chk("rst_vid_h", 32'(vid_h), 32'd0);
    chk("rst_vid_v", 32'(vid_v), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
  endtask

  initial begin
    int k, n;
    #2 reset_n = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Idle raster
    idle(45);

    // Full frame of ramp pixels, then directed pixel order check
    gap_max = 0;
    send_pkt(4'h0, 8, 1);
    wait_lock("s2_lock");
    chk("s2_lock_phase", 32'(t % FT), 32'd0);
    k = 0; n = 0;
    while (k < 8 && n < 40) begin
      step();
      n++;
      if (vid_datavalid) begin
        chk("s2_pixel", 32'(vid_data), 32'(k + 1));
        k++;
      end
    end
    chk("s2_pixel_count", 32'(k), 32'd8);
    idle(40);

    // Short packet underflows, then relock
    gap_max = 1;
    send_pkt(4'h0, 6, 32'h100);
    wait_lock("s3_lock");
    idle(40);
    send_pkt(4'h0, 8, -1);
    wait_lock("s3_relock");
    idle(40);

    // Control packet ahead of video
    send_pkt(4'hF, 3, 32'hABC000);
    send_pkt(4'h0, 8, -1);
    wait_lock("s4_lock");
    idle(40);

    // Back-to-back frames faster than the raster
    gap_max = 0;
    for (int f = 0; f < 4; f++) send_pkt(4'h0, 8, -1);
    idle(80);

    // Random packet mix
    for (int i = 0; i < 14; i++) begin
      gap_max = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0)
        send_pkt(4'($urandom_range(1, 15)), $urandom_range(0, 4), -1);
      else
        send_pkt(4'h0, $urandom_range(6, 9), -1);
    end
    idle(80);

    // Reset in the middle of line 1 while locked
    gap_max = 0;
    send_pkt(4'h0, 8, -1);
    wait_lock("s6_lock");
    n = 0;
    while ((t % FT) != 9 && n < 60) begin
      step();
      n++;
    end
    #2 reset_n = 1'b0;
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    idle(45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
